seven_seg_decoder: RTL and testbench

Receive-side counterpart of the seven-segment scan controller: samples a multiplexed, active-low cathode/anode bus, such as the one driven by a display controller or another board's display header. It recovers the eight hex digits being shown and presents them as a 32-bit word with a one-cycle valid pulse per complete frame. It sits at the I/O boundary in loopback/self-test and board-to-board capture paths.

---
 rtl/seven_seg_decoder.sv | 136 +++++++++++++
 tb/tb_seven_seg_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - recovers eight hex digits from a multiplexed active-low seven-segment bus.
// Optional build macro: SEVEN_SEG_DECODER_CHANGE_ONLY_EN (publish only changed words or the first after stale).
module seven_seg_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [6:0]  cat_in,
  input  logic [7:0]  an_in,
  output logic [31:0] val_out,
  output logic        valid_out,
  output logic        err_out,
  output logic        stale_out
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

  // Raw bus kept as {cat, an}; all-ones is the idle (nothing lit) state.
  logic [14:0]   sync1, sync2, prev;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] idle_cnt;
  logic          armed;
  logic [7:0]    mask;
  logic [31:0]   shadow;

  logic [6:0]  seg;
  logic [7:0]  sel;
  logic        changed, sel_changed, onehot, capture, ok, publish;
  logic [3:0]  nib;
  logic [2:0]  idx;
  logic [7:0]  new_mask;
  logic [31:0] shadow_upd;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    seg         = ~sync2[14:8];
    sel         = ~sync2[7:0];
    changed     = (sync2 != prev);
    sel_changed = (sync2[7:0] != prev[7:0]);
    onehot      = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
    // The data must also be unchanged this cycle, so a saturated count never captures a fresh value.
    capture     = armed && !changed && onehot && (settle_cnt == SETTLE_MAX);
    {ok, nib}   = decode(seg);
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) idx = 3'(i);
    end
    new_mask   = mask | sel;
    shadow_upd = shadow;
    shadow_upd[idx*4 +: 4] = nib;
  end

`ifdef SEVEN_SEG_DECODER_CHANGE_ONLY_EN
  assign publish = stale_out || (shadow_upd != val_out);
`else
  assign publish = 1'b1;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1      <= '1;
      sync2      <= '1;
      prev       <= '1;
      settle_cnt <= '0;
      idle_cnt   <= '0;
      armed      <= 1'b1;
      mask       <= 8'd0;
      shadow     <= 32'd0;
      val_out    <= 32'd0;
      valid_out  <= 1'b0;
      err_out    <= 1'b0;
      stale_out  <= 1'b1;
    end else begin
      sync1 <= {cat_in, an_in};
      sync2 <= sync1;
      prev  <= sync2;
      if (changed) settle_cnt <= '0;
      else if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + SW'(1);
      if (sel_changed) armed <= 1'b1;
      else if (capture) armed <= 1'b0;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
      if (capture) begin
        idle_cnt <= '0;
        if (ok) begin
          shadow <= shadow_upd;
          if (new_mask == 8'hFF) begin
            mask      <= 8'd0;
            stale_out <= 1'b0;
            if (publish) begin
              val_out   <= shadow_upd;
              valid_out <= 1'b1;
            end
          end else begin
            mask <= new_mask;
          end
        end else begin
          err_out <= 1'b1;
          mask    <= 8'd0;
        end
      end else if (idle_cnt == TIMEOUT_MAX) begin
        idle_cnt  <= '0;
        mask      <= 8'd0;
        stale_out <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_decoder.sv
// tb/tb_seven_seg_decoder.sv - directed self-checking bench for seven_seg_decoder.
module tb_seven_seg_decoder;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 300;
  localparam int DWELL   = 40;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [6:0]  cat_in;
  logic [7:0]  an_in;
  logic [31:0] val_out;
  logic        valid_out, err_out, stale_out;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [31:0] last_val = 32'd0;

  seven_seg_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .cat_in(cat_in), .an_in(an_in),
    .val_out(val_out), .valid_out(valid_out), .err_out(err_out), .stale_out(stale_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (valid_out) begin
      valid_cnt = valid_cnt + 1;
      last_val  = val_out;
    end
    if (err_out) err_cnt = err_cnt + 1;
    if (valid_out && err_out) both_cnt = both_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 7'h3F;  4'h1: seg_of = 7'h06;  4'h2: seg_of = 7'h5B;  4'h3: seg_of = 7'h4F;
      4'h4: seg_of = 7'h66;  4'h5: seg_of = 7'h6D;  4'h6: seg_of = 7'h7D;  4'h7: seg_of = 7'h07;
      4'h8: seg_of = 7'h7F;  4'h9: seg_of = 7'h6F;  4'hA: seg_of = 7'h77;  4'hB: seg_of = 7'h7C;
      4'hC: seg_of = 7'h39;  4'hD: seg_of = 7'h5E;  4'hE: seg_of = 7'h79;  default: seg_of = 7'h71;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic show(input int k, input logic [6:0] s);
    an_in  = ~(8'b1 << k);
    cat_in = ~s;
    repeat (DWELL) @(posedge clk_in);
    #2;
  endtask

  task automatic blank(input int n);
    an_in  = 8'hFF;
    cat_in = 7'h7F;
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic scan_digits(input logic [31:0] w, input int first, input int last);
    for (int k = first; k <= last; k++) show(k, seg_of(w[4*k +: 4]));
  endtask

  task automatic do_reset();
    an_in  = 8'hFF;
    cat_in = 7'h7F;
    rst_in = 1'b1;
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
  endtask

  int v0, e0, first;
  int exp_same;

  initial begin
    rst_in = 1'b1;
    an_in  = 8'hFF;
    cat_in = 7'h7F;
    repeat (3) @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    check("reset_val", val_out, 32'd0);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_err", 32'(err_out), 32'd0);
    check("reset_stale", 32'(stale_out), 32'd1);

`ifdef SEVEN_SEG_DECODER_CHANGE_ONLY_EN
    exp_same = 0;
`else
    exp_same = 1;
`endif

    // Basic frame and repeated identical frame
    v0 = valid_cnt;
    scan_digits(32'h1234ABCD, 0, 7);
    check("frame1_pulses", 32'(valid_cnt - v0), 32'd1);
    check("frame1_last", last_val, 32'h1234ABCD);
    check("frame1_val", val_out, 32'h1234ABCD);
    check("frame1_stale", 32'(stale_out), 32'd0);
    scan_digits(32'h1234ABCD, 0, 7);
    check("frame2_pulses", 32'(valid_cnt - v0), 32'(1 + exp_same));
    check("frame_no_err", 32'(err_cnt), 32'd0);

    // Unrecognized digit aborts the frame
    do_reset();
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int k = 0; k < 8; k++)
      show(k, (k == 3) ? 7'h55 : seg_of(4'(32'h1234ABCD >> (4*k))));
    check("bad_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("bad_no_valid", 32'(valid_cnt - v0), 32'd0);
    scan_digits(32'h1234ABCD, 0, 7);
    check("clean_after_bad", 32'(valid_cnt - v0), 32'd1);
    check("clean_after_bad_val", last_val, 32'h1234ABCD);
    show(5, 7'h55);
    show(6, 7'h55);
    check("bad_two_dwells", 32'(err_cnt - e0), 32'd3);

    // Unsettled toggling never captures; stable hold captures with fixed latency
    do_reset();
    v0 = valid_cnt;
    e0 = err_cnt;
    an_in = 8'hFE;
    for (int i = 0; i < 200; i++) begin
      cat_in = (i % 2 == 1) ? ~7'h55 : ~7'h54;
      repeat (5) @(posedge clk_in);
      #2;
    end
    check("toggle_no_err", 32'(err_cnt - e0), 32'd0);
    check("toggle_no_valid", 32'(valid_cnt - v0), 32'd0);
    cat_in = ~7'h57;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_in);
      #2;
      if (err_out && first == 0) first = k;
    end
    check("settle_latency", 32'(first), 32'd19);
    check("settle_single", 32'(err_cnt - e0), 32'd1);

    // Timeout discards a partial frame
    do_reset();
    scan_digits(32'h0F1E2D3C, 0, 7);
    check("to_first_stale", 32'(stale_out), 32'd0);
    v0 = valid_cnt;
    scan_digits(32'h89ABCDEF, 0, 4);
    check("to_partial_stale", 32'(stale_out), 32'd0);
    blank(TIMEOUT + 20);
    check("to_stale_set", 32'(stale_out), 32'd1);
    scan_digits(32'h89ABCDEF, 5, 7);
    check("to_resume_none", 32'(valid_cnt - v0), 32'd0);
    scan_digits(32'h89ABCDEF, 0, 4);
    check("to_resume_full", 32'(valid_cnt - v0), 32'd1);
    check("to_resume_val", last_val, 32'h89ABCDEF);
    check("to_resume_stale", 32'(stale_out), 32'd0);

    // Reset mid-frame
    scan_digits(32'h1234ABCD, 0, 7);
    scan_digits(32'h76543210, 0, 6);
    blank(4);
    do_reset();
    check("mid_rst_val", val_out, 32'd0);
    check("mid_rst_stale", 32'(stale_out), 32'd1);
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    v0 = valid_cnt;
    show(7, seg_of(4'h7));
    scan_digits(32'h76543210, 0, 5);
    check("mid_rst_seven", 32'(valid_cnt - v0), 32'd0);
    show(6, seg_of(4'h6));
    check("mid_rst_eight", 32'(valid_cnt - v0), 32'd1);
    check("mid_rst_frame", last_val, 32'h76543210);

    // Repeated word, then a one-digit change
    do_reset();
    v0 = valid_cnt;
    for (int f = 0; f < 3; f++) scan_digits(32'hDEADBEEF, 0, 7);
    check("same3_pulses", 32'(valid_cnt - v0), 32'(1 + 2 * exp_same));
    check("same3_val", val_out, 32'hDEADBEEF);
    scan_digits(32'hDEADBEE0, 0, 7);
    check("change_pulses", 32'(valid_cnt - v0), 32'(2 + 2 * exp_same));
    check("change_val", val_out, 32'hDEADBEE0);

    check("never_both", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
